// File: rtl/blake_pkg.sv
// Shared constants and sequencer state encoding for the BLAKE-512 compression core.
package blake_pkg;

    localparam int ROUNDS      = 16;
    localparam int G_PER_ROUND = 8;
    localparam int IDX_W       = 7;
    localparam int SIGMA_ROWS  = 10;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        OUT   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/blake_sigma_sel.sv
// Round number to sigma permutation row: BLAKE-512 reuses the ten sigma rows
// cyclically, so rounds 10..15 fold back onto rows 0..5.
module blake_sigma_sel (
    input  logic [3:0] round_num,
    output logic [3:0] sigma_sel
);
    import blake_pkg::*;

    localparam logic [3:0] ROWS = 4'(SIGMA_ROWS);

    logic w_wrap;

    assign w_wrap    = (round_num >= ROWS);
    assign sigma_sel = w_wrap ? (round_num - ROWS) : round_num;

endmodule

// File: rtl/blake_round_seq.sv
// Round sequencer: block handshake, 128-step G schedule in lockstep with the
// external round counter, finalization strobe and backpressured result.
module blake_round_seq #(
    parameter int ROUNDS      = blake_pkg::ROUNDS,
    parameter int G_PER_ROUND = blake_pkg::G_PER_ROUND,
    parameter int IDX_W       = blake_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             blk_valid,
    input  logic             blk_last,
    output logic             blk_ready,
    input  logic [IDX_W-1:0] counter_idx,
    input  logic             count_done,
    output logic             round_ing,
    output logic             init_load,
    output logic             g_en,
    output logic [3:0]       round_num,
    output logic [2:0]       g_sel,
    output logic [3:0]       sigma_sel,
    output logic             fin_en,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy,
    output logic             seq_err,
    output logic [2:0]       dbg_state
);
    import blake_pkg::*;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a source keeps valid (and its data) stable until that edge.

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROUNDS * G_PER_ROUND - 1);

    seq_state_t       r_state;
    logic             r_blk_ready;
    logic             r_round_ing;
    logic             r_init_load;
    logic             r_g_en;
    logic             r_fin_en;
    logic             r_out_valid;
    logic             r_out_last;
    logic             r_busy;
    logic             r_last;
    logic             r_seq_err;
    logic [IDX_W-1:0] r_shadow;

    logic [3:0]       w_round_num;
    logic             w_idx_slip;
    logic             w_early_done;

    assign w_round_num  = counter_idx[IDX_W-1 -: 4];
    assign w_idx_slip   = (counter_idx != r_shadow);
    assign w_early_done = count_done && (r_shadow != IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_blk_ready <= 1'b1;
            r_round_ing <= 1'b0;
            r_init_load <= 1'b0;
            r_g_en      <= 1'b0;
            r_fin_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_last      <= 1'b0;
            r_seq_err   <= 1'b0;
            r_shadow    <= '0;
        end else begin
            r_init_load <= 1'b0;
            r_fin_en    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (blk_valid) begin
                        r_last      <= blk_last;
                        r_state     <= INIT;
                        r_blk_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_init_load <= 1'b1;
                    end
                end
                INIT: begin
                    r_shadow    <= '0;
                    r_state     <= ROUND;
                    r_round_ing <= 1'b1;
                    r_g_en      <= 1'b1;
                end
                ROUND: begin
                    r_shadow <= r_shadow + 1'b1;
                    if (w_idx_slip || w_early_done) begin
                        r_seq_err <= 1'b1;
                    end
                    // A premature count_done is flagged but still ends the block,
                    // so the core never stalls waiting on a broken counter.
                    if (count_done) begin
                        r_state     <= FINAL;
                        r_round_ing <= 1'b0;
                        r_g_en      <= 1'b0;
                        r_fin_en    <= 1'b1;
                    end
                end
                FINAL: begin
                    r_state     <= OUT;
                    r_out_valid <= 1'b1;
                    r_out_last  <= r_last;
                end
                OUT: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_blk_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_blk_ready <= 1'b1;
                    r_round_ing <= 1'b0;
                    r_g_en      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    blake_sigma_sel u_sigma_sel (
        .round_num (w_round_num),
        .sigma_sel (sigma_sel)
    );

    assign blk_ready = r_blk_ready;
    assign round_ing = r_round_ing;
    assign init_load = r_init_load;
    assign g_en      = r_g_en;
    assign round_num = w_round_num;
    assign g_sel     = counter_idx[2:0];
    assign fin_en    = r_fin_en;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign seq_err   = r_seq_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_blake_round_seq.sv
// Directed bench for blake_round_seq with a behavioural round counter attached.
module tb_blake_round_seq;
    import blake_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       blk_valid = 1'b0;
    logic       blk_last = 1'b0;
    logic       blk_ready;
    logic [6:0] counter_idx;
    logic       count_done;
    logic       round_ing;
    logic       init_load;
    logic       g_en;
    logic [3:0] round_num;
    logic [2:0] g_sel;
    logic [3:0] sigma_sel;
    logic       fin_en;
    logic       out_valid;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       seq_err;
    logic [2:0] dbg_state;

    logic [6:0] cnt_q = '0;
    logic       force_en = 1'b0;
    logic [6:0] force_val = '0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         hs_q[$];
    logic [0:0] exp_q[$];

    always #5 clk = ~clk;

    blake_round_seq dut (
        .clk         (clk),
        .rst         (rst),
        .blk_valid   (blk_valid),
        .blk_last    (blk_last),
        .blk_ready   (blk_ready),
        .counter_idx (counter_idx),
        .count_done  (count_done),
        .round_ing   (round_ing),
        .init_load   (init_load),
        .g_en        (g_en),
        .round_num   (round_num),
        .g_sel       (g_sel),
        .sigma_sel   (sigma_sel),
        .fin_en      (fin_en),
        .out_valid   (out_valid),
        .out_last    (out_last),
        .out_ready   (out_ready),
        .busy        (busy),
        .seq_err     (seq_err),
        .dbg_state   (dbg_state)
    );

    // Round counter model: clears while round_ing is low, counts while high.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!round_ing) cnt_q <= '0;
        else            cnt_q <= cnt_q + 7'd1;
    end
    assign counter_idx = force_en ? force_val : cnt_q;
    assign count_done  = (cnt_q == 7'd127);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each result handshake consumes one expected out_last.
    always @(negedge clk) begin
        if (!rst && blk_valid && blk_ready) hs_q.push_back(cyc);
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 32'(out_valid), 32'd0);
            else                   check("out_last", 32'(out_last), 32'(exp_q.pop_front()));
        end
    end

    task automatic start_block(input logic last);
        int n = 0;
        blk_valid = 1'b1;
        blk_last  = last;
        while (!blk_ready && n < 10) begin
            tick();
            n++;
        end
        check("blk_ready_wait", 32'(blk_ready), 32'd1);
        tick();
        blk_valid = 1'b0;
    endtask

    task automatic run_block(input logic last, input int bp, input int fault_at);
        int i = 0;
        exp_q.push_back(last);
        start_block(last);
        check("init_load_c1", 32'(init_load), 32'd1);
        check("state_init", 32'(dbg_state), 32'(INIT));
        check("blk_ready_busy", 32'(blk_ready), 32'd0);
        check("busy_c1", 32'(busy), 32'd1);
        tick();
        check("init_load_c2", 32'(init_load), 32'd0);
        while (g_en === 1'b1 && i < 200) begin
            if (i == 0)   check("round_ing_c2", 32'(round_ing), 32'd1);
            if (i == 45)  check("dec45", {g_sel, round_num, sigma_sel}, {3'd5, 4'd5, 4'd5});
            if (i == 87)  check("dec87", {g_sel, round_num, sigma_sel}, {3'd7, 4'd10, 4'd0});
            if (i == 100) check("dec100", {g_sel, round_num, sigma_sel}, {3'd4, 4'd12, 4'd2});
            if (i == 127) check("dec127", {g_sel, round_num, sigma_sel}, {3'd7, 4'd15, 4'd5});
            if (i == fault_at) begin
                check("seq_err_pre", 32'(seq_err), 32'd0);
                force_en  = 1'b1;
                force_val = 7'd5;
            end
            tick();
            force_en = 1'b0;
            i++;
            if (fault_at >= 0 && i == fault_at + 1) check("seq_err_set", 32'(seq_err), 32'd1);
        end
        check("g_en_cycles", 32'(i), 32'd128);
        check("fin_en", 32'(fin_en), 32'd1);
        check("state_final", 32'(dbg_state), 32'(FINAL));
        check("round_ing_final", 32'(round_ing), 32'd0);
        tick();
        check("fin_en_once", 32'(fin_en), 32'd0);
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_last_drv", 32'(out_last), 32'(last));
        for (int k = 0; k < bp; k++) begin
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_blk_ready", 32'(blk_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("state_idle", 32'(dbg_state), 32'(IDLE));
        check("blk_ready_idle", 32'(blk_ready), 32'd1);
        check("out_valid_drop", 32'(out_valid), 32'd0);
        check("seq_err_end", 32'(seq_err), (fault_at >= 0) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_outs", {blk_ready, round_ing, init_load, g_en, fin_en, out_valid, out_last, busy, seq_err},
              {1'b1, 8'b0});
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;
        tick();
        check("idle_hold", {blk_ready, busy}, {1'b1, 1'b0});

        // Single block, then the same with 20 cycles of backpressure
        run_block(1'b1, 0, -1);
        run_block(1'b0, 20, -1);

        // Back-to-back blocks with blk_valid held high
        hs_q.delete();
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        out_ready = 1'b1;
        blk_valid = 1'b1;
        blk_last  = 1'b0;
        n = 0;
        while (hs_q.size() < 1 && n < 10) begin tick(); n++; end
        blk_last = 1'b1;
        n = 0;
        while (hs_q.size() < 2 && n < 300) begin tick(); n++; end
        blk_valid = 1'b0;
        check("b2b_handshakes", 32'(hs_q.size()), 32'd2);
        if (hs_q.size() >= 2) check("b2b_gap", 32'(hs_q[1] - hs_q[0]), 32'd132);
        n = 0;
        while (!(blk_ready && exp_q.size() == 0) && n < 300) begin tick(); n++; end
        out_ready = 1'b0;
        check("b2b_drain", 32'(exp_q.size()), 32'd0);

        // Lockstep fault on the 4th ROUND cycle
        run_block(1'b1, 2, 3);

        // Mid-operation reset at shadow count 60
        start_block(1'b0);
        n = 0;
        while (counter_idx != 7'd60 && n < 100) begin tick(); n++; end
        check("midop_reach60", 32'(counter_idx), 32'd60);
        check("midop_err_before", 32'(seq_err), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midop_state", 32'(dbg_state), 32'(IDLE));
        check("midop_outs", {round_ing, g_en, seq_err, blk_ready, busy}, {4'b0001, 1'b0});
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 150; k++) begin
            if (fin_en || out_valid) seen++;
            tick();
        end
        out_ready = 1'b0;
        check("midop_no_result", 32'(seen), 32'd0);

        // Recovery block after the abort
        run_block(1'b1, 0, -1);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
